// File: rtl/eq_chk_pkg.sv
// Shared types, defaults and width helper for the delayed equivalence checker.
package eq_chk_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_LATENCY = 3;
    localparam int unsigned DEF_NCH     = 1;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        CHECK  = 2'd1,
        FAILED = 2'd2
    } state_t;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned ceil_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 32'd1;
        return (r == 32'd0) ? 32'd1 : r;
    endfunction

endpackage

// File: rtl/eq_delay_line.sv
// Fixed-latency {valid, data} shift register with no stall; flushed by reset.
module eq_delay_line #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } beat_t;

    beat_t stage [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= '{valid: d_valid, data: d_data};
            for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign q_valid = stage[LATENCY-1].valid;
    assign q_data  = stage[LATENCY-1].data;

endmodule

// File: rtl/eq_delay_checker.sv
// Per-channel masked compare of delayed spec stream against implementation stream,
// with sticky fail, saturating mismatch counter and first-mismatch capture.
module eq_delay_checker
    import eq_chk_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned NCH     = DEF_NCH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    localparam int unsigned CH_W   = ceil_log2(NCH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       ref_valid,
    input  logic [NCH*WIDTH-1:0] ref_data,
    input  logic [NCH-1:0]       dut_valid,
    input  logic [NCH*WIDTH-1:0] dut_data,
    input  logic [WIDTH-1:0]     cmp_mask,
    input  logic                 clear,
    output logic                 prop,
    output logic                 fail,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic [CH_W-1:0]      first_ch,
    output logic [WIDTH-1:0]     first_exp,
    output logic [WIDTH-1:0]     first_got,
    output logic                 armed
);

    localparam int unsigned LAT_W  = ceil_log2(LATENCY);
    localparam int unsigned NMIS_W = ceil_log2(NCH + 1);
    localparam int unsigned SUM_W  = CNT_W + NMIS_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                 state;
    logic [LAT_W-1:0]       warm_cnt;
    logic [NCH-1:0]         q_valid;
    logic [WIDTH-1:0]       q_data [NCH];
    logic [NCH-1:0]         mis;
    logic                   any_mis;
    logic [NMIS_W-1:0]      n_mis;
    logic [CH_W-1:0]        sel_ch;
    logic [WIDTH-1:0]       sel_exp;
    logic [WIDTH-1:0]       sel_got;
    logic [CNT_W-1:0]       cnt_base;
    logic [SUM_W-1:0]       cnt_sum;
    logic [CNT_W-1:0]       cnt_next;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        eq_delay_line #(
            .WIDTH   (WIDTH),
            .LATENCY (LATENCY)
        ) u_dly (
            .clk     (clk),
            .reset   (reset),
            .d_valid (ref_valid[g]),
            .d_data  (ref_data[g*WIDTH +: WIDTH]),
            .q_valid (q_valid[g]),
            .q_data  (q_data[g])
        );
    end

    // Channel compare, mismatch popcount, lowest-index select and saturating sum.
    always_comb begin
        mis      = '0;
        n_mis    = '0;
        sel_ch   = '0;
        sel_exp  = '0;
        sel_got  = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            mis[i] = armed && ((dut_valid[i] != q_valid[i]) ||
                     (dut_valid[i] && q_valid[i] &&
                      (|((dut_data[i*WIDTH +: WIDTH] ^ q_data[i]) & cmp_mask))));
            n_mis  = n_mis + NMIS_W'(mis[i]);
        end
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mis[i]) begin
                sel_ch  = CH_W'(i);
                sel_exp = q_data[i];
                sel_got = dut_data[i*WIDTH +: WIDTH];
            end
        end
        cnt_base = clear ? '0 : mismatch_cnt;
        cnt_sum  = SUM_W'(cnt_base) + SUM_W'(n_mis);
        cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(cnt_sum);
    end

    assign any_mis = |mis;
    assign prop    = ~any_mis;

    // FSM plus sticky debug state; a mismatch always takes priority over clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WARMUP;
            warm_cnt     <= '0;
            armed        <= 1'b0;
            fail         <= 1'b0;
            mismatch_cnt <= '0;
            first_ch     <= '0;
            first_exp    <= '0;
            first_got    <= '0;
        end else begin
            case (state)
                WARMUP: begin
                    if (warm_cnt == LAT_W'(LATENCY - 1)) begin
                        state <= CHECK;
                        armed <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + LAT_W'(1);
                    end
                end
                CHECK:   if (any_mis) state <= FAILED;
                FAILED:  if (clear && !any_mis) state <= CHECK;
                default: state <= WARMUP;
            endcase

            if (armed) begin
                if (any_mis) begin
                    fail         <= 1'b1;
                    mismatch_cnt <= cnt_next;
                    if (!fail || clear) begin
                        first_ch  <= sel_ch;
                        first_exp <= sel_exp;
                        first_got <= sel_got;
                    end
                end else if (clear) begin
                    fail         <= 1'b0;
                    mismatch_cnt <= '0;
                    first_ch     <= '0;
                    first_exp    <= '0;
                    first_got    <= '0;
                end
            end
        end
    end

endmodule
